// File: rtl/prog_loader_if.sv
// Stream-in / memory-write bundle for the program loader.
// The slave modport is the loader's view; the master modport is the producer/observer view.
interface prog_loader_if #(
  parameter int O_SIZE  = 6,
  parameter int R_SIZE  = 3,
  parameter int I_SIZE  = 8,
  parameter int PA_SIZE = 8
);
  localparam int W_SIZE = O_SIZE + 2 * R_SIZE + I_SIZE;

  logic                start;
  logic                in_valid;
  logic                in_ready;
  logic                in_last;
  logic [O_SIZE-1:0]   in_opcode;
  logic [R_SIZE-1:0]   in_rd;
  logic [R_SIZE-1:0]   in_rs;
  logic [I_SIZE-1:0]   in_imm;
  logic                mem_we;
  logic [PA_SIZE-1:0]  mem_addr;
  logic [W_SIZE-1:0]   mem_wdata;
  logic                cpu_hold;
  logic                done;
  logic [PA_SIZE:0]    word_count;
  logic                err_opcode;
  logic                err_overflow;

  modport slave (
    input  start, in_valid, in_last, in_opcode, in_rd, in_rs, in_imm,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done,
           word_count, err_opcode, err_overflow
  );

  modport master (
    output start, in_valid, in_last, in_opcode, in_rd, in_rs, in_imm,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done,
           word_count, err_opcode, err_overflow
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: packs decoded fields into instruction words and writes them
// sequentially from address 0, holding the core idle for the whole load.
module prog_loader #(
  parameter int O_SIZE  = 6,
  parameter int R_SIZE  = 3,
  parameter int I_SIZE  = 8,
  parameter int PA_SIZE = 8
) (
  input  logic           clk,
  input  logic           reset,
  prog_loader_if.slave   bus
);
  localparam int W_SIZE = O_SIZE + 2 * R_SIZE + I_SIZE;

  // Opcode encodings shared with the decoder (cpuConfig::opCode_t).
  localparam logic [O_SIZE-1:0] OP_NOP   = O_SIZE'(0);
  localparam logic [O_SIZE-1:0] OP_LDI   = O_SIZE'(1);
  localparam logic [O_SIZE-1:0] OP_LDS   = O_SIZE'(2);
  localparam logic [O_SIZE-1:0] OP_ADD   = O_SIZE'(3);
  localparam logic [O_SIZE-1:0] OP_ADDI  = O_SIZE'(4);
  localparam logic [O_SIZE-1:0] OP_MUL   = O_SIZE'(5);
  localparam logic [O_SIZE-1:0] OP_WAIT0 = O_SIZE'(6);
  localparam logic [O_SIZE-1:0] OP_WAIT1 = O_SIZE'(7);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FINISH = 2'd2} state_e;

  state_e state_q, state_d;

  logic [PA_SIZE-1:0] ptr_q, ptr_d;
  logic [PA_SIZE:0]   word_count_q, word_count_d;
  logic               err_opcode_q, err_opcode_d;
  logic               err_overflow_q, err_overflow_d;
  logic               mem_we_q, mem_we_d;
  logic [PA_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [W_SIZE-1:0]  mem_wdata_q, mem_wdata_d;

  logic               in_ready;
  logic               xfer;
  logic               ptr_at_end;
  logic               op_legal;
  logic [O_SIZE-1:0]  op_fixed;

  assign xfer       = bus.in_valid && in_ready;
  assign ptr_at_end = (ptr_q == {PA_SIZE{1'b1}});

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = LOAD;
      LOAD:    if (xfer && (bus.in_last || ptr_at_end)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state alone
  always_comb begin
    in_ready     = 1'b0;
    bus.cpu_hold = 1'b0;
    bus.done     = 1'b0;
    case (state_q)
      LOAD:    begin in_ready = 1'b1; bus.cpu_hold = 1'b1; end
      FINISH:  begin bus.cpu_hold = 1'b1; bus.done = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    op_legal = bus.in_opcode inside {OP_NOP, OP_LDI, OP_LDS, OP_ADD,
                                     OP_ADDI, OP_MUL, OP_WAIT0, OP_WAIT1};
    op_fixed = op_legal ? bus.in_opcode : OP_NOP;
  end

  // Datapath: the write port trails the accepted tuple by one cycle.
  always_comb begin
    ptr_d          = ptr_q;
    word_count_d   = word_count_q;
    err_opcode_d   = err_opcode_q;
    err_overflow_d = err_overflow_q;
    mem_we_d       = xfer;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    if (state_q == IDLE && bus.start) begin
      ptr_d          = '0;
      word_count_d   = '0;
      err_opcode_d   = 1'b0;
      err_overflow_d = 1'b0;
    end
    if (xfer) begin
      mem_addr_d   = ptr_q;
      mem_wdata_d  = {op_fixed, bus.in_rd, bus.in_rs, bus.in_imm};
      word_count_d = word_count_q + (PA_SIZE+1)'(1);
      // Pointer parks on the last address rather than wrapping.
      if (!ptr_at_end) ptr_d = ptr_q + PA_SIZE'(1);
      if (!op_legal) err_opcode_d = 1'b1;
      if (ptr_at_end && !bus.in_last) err_overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q          <= '0;
      word_count_q   <= '0;
      err_opcode_q   <= 1'b0;
      err_overflow_q <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
    end else begin
      ptr_q          <= ptr_d;
      word_count_q   <= word_count_d;
      err_opcode_q   <= err_opcode_d;
      err_overflow_q <= err_overflow_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.word_count   = word_count_q;
  assign bus.err_opcode   = err_opcode_q;
  assign bus.err_overflow = err_overflow_q;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a default-size instance plus a PA_SIZE=3
// instance for the memory-full case.
module tb_prog_loader;
  localparam logic [5:0] NOP = 6'd0, LDI = 6'd1, ADD = 6'd3, ADDI = 6'd4, MUL = 6'd5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   wr_a = 0;
  int   wr_b = 0;
  int   wr_mark = 0;

  logic [19:0] exp_gap [4];

  always #5 clk = ~clk;

  prog_loader_if #(.PA_SIZE(8)) bus_a ();
  prog_loader_if #(.PA_SIZE(3)) bus_b ();

  prog_loader #(.PA_SIZE(8)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  prog_loader #(.PA_SIZE(3)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  // Each posedge counts the write that was visible during the preceding cycle.
  always @(posedge clk) begin
    if (bus_a.mem_we === 1'b1) wr_a++;
    if (bus_b.mem_we === 1'b1) wr_b++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive_a(input logic v, input logic last, input logic [5:0] op,
                         input logic [2:0] rd, input logic [2:0] rs, input logic [7:0] imm);
    bus_a.in_valid  = v;
    bus_a.in_last   = last;
    bus_a.in_opcode = op;
    bus_a.in_rd     = rd;
    bus_a.in_rs     = rs;
    bus_a.in_imm    = imm;
  endtask

  initial begin
    // word = {op[19:14], rd[13:11], rs[10:8], imm[7:0]}, op ADD, rd=i, imm=0x10+i
    exp_gap[0] = 20'h0C010;
    exp_gap[1] = 20'h0C811;
    exp_gap[2] = 20'h0D012;
    exp_gap[3] = 20'h0D813;

    bus_a.start = 1'b0;
    drive_a(1'b0, 1'b0, NOP, 3'd0, 3'd0, 8'd0);
    bus_b.start = 1'b0; bus_b.in_valid = 1'b0; bus_b.in_last = 1'b0;
    bus_b.in_opcode = NOP; bus_b.in_rd = 3'd0; bus_b.in_rs = 3'd0; bus_b.in_imm = 8'd0;

    // ---------------- reset state ----------------
    repeat (2) next_cycle();
    mid();
    check("rst_in_ready", bus_a.in_ready, 0);
    check("rst_mem_we", bus_a.mem_we, 0);
    check("rst_mem_addr", bus_a.mem_addr, 0);
    check("rst_mem_wdata", bus_a.mem_wdata, 0);
    check("rst_cpu_hold", bus_a.cpu_hold, 0);
    check("rst_done", bus_a.done, 0);
    check("rst_word_count", bus_a.word_count, 0);
    check("rst_err_opcode", bus_a.err_opcode, 0);
    check("rst_err_overflow", bus_a.err_overflow, 0);
    check("rst_b_in_ready", bus_b.in_ready, 0);
    next_cycle();
    reset = 1'b0;

    // ---------------- back-to-back load of three words ----------------
    wr_mark = wr_a;
    bus_a.start = 1'b1;
    mid();
    check("t1_idle_hold", bus_a.cpu_hold, 0);
    check("t1_idle_ready", bus_a.in_ready, 0);
    next_cycle();
    bus_a.start = 1'b0;
    drive_a(1'b1, 1'b0, LDI, 3'd1, 3'd0, 8'd5);
    mid();
    check("t1_load_ready", bus_a.in_ready, 1);
    check("t1_load_hold", bus_a.cpu_hold, 1);
    check("t1_no_we_yet", bus_a.mem_we, 0);
    next_cycle();
    drive_a(1'b1, 1'b0, ADDI, 3'd1, 3'd0, 8'd3);
    mid();
    check("t1_we0", bus_a.mem_we, 1);
    check("t1_addr0", bus_a.mem_addr, 0);
    check("t1_data0", bus_a.mem_wdata, 20'h04805);
    next_cycle();
    drive_a(1'b1, 1'b1, MUL, 3'd1, 3'd2, 8'd0);
    mid();
    check("t1_we1", bus_a.mem_we, 1);
    check("t1_addr1", bus_a.mem_addr, 1);
    check("t1_data1", bus_a.mem_wdata, 20'h10803);
    next_cycle();
    drive_a(1'b0, 1'b0, NOP, 3'd0, 3'd0, 8'd0);
    mid();
    check("t1_we2", bus_a.mem_we, 1);
    check("t1_addr2", bus_a.mem_addr, 2);
    check("t1_data2", bus_a.mem_wdata, 20'h14A00);
    check("t1_done", bus_a.done, 1);
    check("t1_fin_hold", bus_a.cpu_hold, 1);
    check("t1_fin_ready", bus_a.in_ready, 0);
    check("t1_count_fin", bus_a.word_count, 3);
    next_cycle();
    mid();
    check("t1_idle_we", bus_a.mem_we, 0);
    check("t1_idle_done", bus_a.done, 0);
    check("t1_idle_hold2", bus_a.cpu_hold, 0);
    check("t1_count_idle", bus_a.word_count, 3);
    next_cycle();
    check("t1_writes", wr_a - wr_mark, 3);

    // ---------------- gapped stream, one tuple every third cycle ----------------
    wr_mark = wr_a;
    bus_a.start = 1'b1;
    next_cycle();
    bus_a.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, (i == 3), ADD, 3'(i), 3'd0, 8'(8'h10 + i));
      mid();
      check("t2_xfer_no_we", bus_a.mem_we, 0);
      next_cycle();
      drive_a(1'b0, 1'b0, NOP, 3'd0, 3'd0, 8'd0);
      mid();
      check("t2_we", bus_a.mem_we, 1);
      check("t2_addr", bus_a.mem_addr, 64'(i));
      check("t2_data", bus_a.mem_wdata, exp_gap[i]);
      if (i == 3) check("t2_done", bus_a.done, 1);
      next_cycle();
      if (i < 3) begin
        mid();
        check("t2_gap_no_we", bus_a.mem_we, 0);
        next_cycle();
      end
    end
    mid();
    check("t2_count", bus_a.word_count, 4);
    next_cycle();
    check("t2_writes", wr_a - wr_mark, 4);

    // ---------------- illegal opcode ----------------
    bus_a.start = 1'b1;
    next_cycle();
    bus_a.start = 1'b0;
    drive_a(1'b1, 1'b1, 6'h2A, 3'd2, 3'd0, 8'hAA);
    mid();
    check("t3_err_clear", bus_a.err_opcode, 0);
    next_cycle();
    drive_a(1'b0, 1'b0, NOP, 3'd0, 3'd0, 8'd0);
    mid();
    check("t3_we", bus_a.mem_we, 1);
    check("t3_data_nop", bus_a.mem_wdata, 20'h010AA);
    check("t3_err_set", bus_a.err_opcode, 1);
    check("t3_done", bus_a.done, 1);
    repeat (3) next_cycle();
    mid();
    check("t3_err_sticky", bus_a.err_opcode, 1);
    check("t3_count", bus_a.word_count, 1);
    next_cycle();

    // ---------------- reset mid-load after two transfers ----------------
    bus_a.start = 1'b1;
    next_cycle();
    bus_a.start = 1'b0;
    mid();
    check("t5_err_cleared", bus_a.err_opcode, 0);
    check("t5_count_cleared", bus_a.word_count, 0);
    drive_a(1'b1, 1'b0, NOP, 3'd0, 3'd0, 8'd1);
    next_cycle();
    drive_a(1'b1, 1'b0, NOP, 3'd0, 3'd0, 8'd2);
    next_cycle();
    drive_a(1'b1, 1'b0, NOP, 3'd0, 3'd0, 8'd3);
    reset = 1'b1;
    mid();
    check("t5_pre_rst_addr", bus_a.mem_addr, 1);
    next_cycle();
    reset = 1'b0;
    mid();
    check("t5_rst_ready", bus_a.in_ready, 0);
    check("t5_rst_hold", bus_a.cpu_hold, 0);
    check("t5_rst_we", bus_a.mem_we, 0);
    next_cycle();
    mid();
    check("t5_idle_valid_no_we", bus_a.mem_we, 0);
    next_cycle();
    drive_a(1'b0, 1'b0, NOP, 3'd0, 3'd0, 8'd0);
    bus_a.start = 1'b1;
    next_cycle();
    bus_a.start = 1'b0;
    drive_a(1'b1, 1'b1, NOP, 3'd0, 3'd0, 8'h44);
    mid();
    check("t5_restart_count", bus_a.word_count, 0);
    next_cycle();
    drive_a(1'b0, 1'b0, NOP, 3'd0, 3'd0, 8'd0);
    mid();
    check("t5_restart_addr", bus_a.mem_addr, 0);
    check("t5_restart_data", bus_a.mem_wdata, 20'h00044);
    next_cycle();
    next_cycle();

    // ---------------- start pulsed mid-load ----------------
    bus_a.start = 1'b1;
    next_cycle();
    drive_a(1'b1, 1'b0, NOP, 3'd0, 3'd0, 8'd7);
    next_cycle();
    bus_a.start = 1'b0;
    drive_a(1'b1, 1'b0, NOP, 3'd0, 3'd0, 8'd8);
    mid();
    check("t6_addr0", bus_a.mem_addr, 0);
    next_cycle();
    bus_a.start = 1'b1;
    drive_a(1'b1, 1'b1, NOP, 3'd0, 3'd0, 8'd9);
    mid();
    check("t6_addr1", bus_a.mem_addr, 1);
    next_cycle();
    bus_a.start = 1'b0;
    drive_a(1'b0, 1'b0, NOP, 3'd0, 3'd0, 8'd0);
    mid();
    check("t6_addr2", bus_a.mem_addr, 2);
    check("t6_data2", bus_a.mem_wdata, 20'h00009);
    check("t6_done", bus_a.done, 1);
    next_cycle();

    // ---------------- memory overflow on the PA_SIZE=3 instance ----------------
    bus_b.start = 1'b1;
    next_cycle();
    bus_b.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_b.in_valid = 1'b1;
      bus_b.in_imm   = 8'(i);
      mid();
      check("t4_ready", bus_b.in_ready, 1);
      if (i > 0) check("t4_addr", bus_b.mem_addr, 64'(i - 1));
      next_cycle();
    end
    bus_b.in_imm = 8'd8;
    mid();
    check("t4_ready_low", bus_b.in_ready, 0);
    check("t4_we7", bus_b.mem_we, 1);
    check("t4_addr7", bus_b.mem_addr, 7);
    check("t4_data7", bus_b.mem_wdata, 20'h00007);
    check("t4_done", bus_b.done, 1);
    check("t4_overflow", bus_b.err_overflow, 1);
    check("t4_count", bus_b.word_count, 8);
    next_cycle();
    mid();
    check("t4_idle_we", bus_b.mem_we, 0);
    check("t4_idle_hold", bus_b.cpu_hold, 0);
    next_cycle();
    bus_b.in_valid = 1'b0;
    mid();
    check("t4_idle_we2", bus_b.mem_we, 0);
    check("t4_overflow_sticky", bus_b.err_overflow, 1);
    next_cycle();
    check("t4_writes", wr_b, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
